// File: rtl/pin_entry_collector.sv
// Keypad front end: collects octal digits into a fixed-length PIN and presents it
// as a password attempt with a one-cycle valid strobe. All outputs are registered.
module pin_entry_collector #(
  parameter int unsigned NUM_DIGITS  = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned PIN_W      = NUM_DIGITS * 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_en,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [PIN_W-1:0] psswrd_atmpt,
  output logic             atmpt_valid,
  output logic             key_error,
  output logic             entry_timeout,
  output logic [1:0]       digit_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] IdleMax = CW'(TIMEOUT_CYC - 1);
  localparam logic [1:0] CntFull = 2'(NUM_DIGITS);
  localparam logic [3:0] KeyClr = 4'hA;
  localparam logic [3:0] KeyEnt = 4'hB;

  typedef enum logic [1:0] {StIdle, StCollect, StPresent} state_e;

  state_e            state_q, state_d;
  logic [PIN_W-1:0]  buf_q, buf_d;
  logic [PIN_W-1:0]  atmpt_q, atmpt_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CW-1:0]     idle_q, idle_d;
  logic              av_q, av_d;
  logic              ke_q, ke_d;
  logic              to_q, to_d;
  logic              is_digit;

  assign is_digit = (key_code[3] == 1'b0);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    atmpt_d = atmpt_q;
    av_d    = 1'b0;
    ke_d    = 1'b0;
    to_d    = 1'b0;

    if (!entry_en) begin
      // Leaving entry mode abandons any partial PIN silently.
      state_d = StIdle;
      buf_d   = '0;
      cnt_d   = '0;
      idle_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCollect;
          buf_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
        end
        StPresent: begin
          state_d = StCollect;
          buf_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
          ke_d    = key_valid;
        end
        StCollect: begin
          if (key_valid) begin
            idle_d = '0;
            if (is_digit) begin
              if (cnt_q < CntFull) begin
                buf_d = (buf_q << 3) | PIN_W'(key_code[2:0]);
                cnt_d = cnt_q + 2'd1;
              end else begin
                ke_d = 1'b1;
              end
            end else if (key_code == KeyClr) begin
              buf_d = '0;
              cnt_d = '0;
            end else if (key_code == KeyEnt) begin
              if (cnt_q == CntFull) begin
                state_d = StPresent;
                atmpt_d = buf_q;
                av_d    = 1'b1;
              end else begin
                ke_d  = 1'b1;
                buf_d = '0;
                cnt_d = '0;
              end
            end else begin
              ke_d = 1'b1;
            end
          end else if (cnt_q != 2'd0) begin
            if (idle_q == IdleMax) begin
              to_d   = 1'b1;
              buf_d  = '0;
              cnt_d  = '0;
              idle_d = '0;
            end else begin
              idle_d = idle_q + CW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      atmpt_q <= '0;
      av_q    <= 1'b0;
      ke_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      atmpt_q <= atmpt_d;
      av_q    <= av_d;
      ke_q    <= ke_d;
      to_q    <= to_d;
    end
  end

  assign psswrd_atmpt  = atmpt_q;
  assign atmpt_valid   = av_q;
  assign key_error     = ke_q;
  assign entry_timeout = to_q;
  assign digit_cnt     = cnt_q;

endmodule
